// File: rtl/crop_video_axis_src_pkg_hdl.sv
// Purpose: shared types and sizes for the crop-output geometry checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package crop_video_axis_src_pkg_hdl;

    localparam int DIM_BITS_DFLT = 12;
    localparam int FRAME_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BYPASS = 2'd2
    } geom_state_e;

endpackage

// File: rtl/crop_video_axis_skid.sv
// Purpose: 2-entry skid buffer between the upstream stream and the downstream port.
// Latency: 1 cycle from accept to output valid; one beat per cycle sustained.
// Backpressure: s_rdy is registered and low only while both entries are occupied.
// Ports: clk/rst; s_vld/s_rdy/s_dat upstream; m_vld/m_rdy/m_dat downstream.
module crop_video_axis_skid #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] s_dat,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic [WIDTH-1:0] m_dat
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_nxt;
    logic             push;
    logic             pop;

    assign push  = s_vld & s_rdy;
    assign pop   = m_vld & m_rdy;
    assign m_vld = (cnt_q != 2'd0);
    assign m_dat = mem_q[rd_ptr_q];

    always_comb begin
        cnt_nxt = cnt_q;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + 2'd1;
            2'b01:   cnt_nxt = cnt_q - 2'd1;
            default: cnt_nxt = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            s_rdy    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_nxt;
            // Ready follows the occupancy we are about to have, so it is
            // registered yet never lets a push land on a full buffer.
            s_rdy <= (cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/crop_video_axis_geom_chk.sv
// Purpose: forward the crop core's AXI-Stream output and check frame geometry.
// Latency: 1 cycle through the skid buffer; frame_done 1 cycle after the last beat.
// Backpressure: m00 tready stalls propagate via the registered s00_axis_tready.
// Ports: clk/rst; s00_axis_* in; m00_axis_* out; cfg_width/cfg_height, clr_err in;
//        frame_done, frame_count, sticky err_* flags out.
module crop_video_axis_geom_chk
    import crop_video_axis_src_pkg_hdl::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TSTRB_WIDTH = 4,
    parameter int DIM_BITS    = DIM_BITS_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [TSTRB_WIDTH-1:0] s00_axis_tstrb,
    input  logic                   s00_axis_tlast,
    input  logic                   s00_axis_tuser,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic [TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [TSTRB_WIDTH-1:0] m00_axis_tstrb,
    output logic                   m00_axis_tlast,
    output logic                   m00_axis_tuser,
    input  logic [DIM_BITS-1:0]    cfg_width,
    input  logic [DIM_BITS-1:0]    cfg_height,
    input  logic                   clr_err,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_no_sof,
    output logic                   err_sof_mid,
    output logic                   err_eol_early,
    output logic                   err_eol_late,
    output logic                   err_cfg
);

    localparam int PW = TDATA_WIDTH + TSTRB_WIDTH + 2;
    localparam logic [DIM_BITS-1:0]    DIM_ONE = {{(DIM_BITS-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_W-1:0] FC_ONE  = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

    logic [PW-1:0] s_dat;
    logic [PW-1:0] m_dat;

    assign s_dat = {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tuser};

    crop_video_axis_skid #(.WIDTH(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .s_vld (s00_axis_tvalid),
        .s_rdy (s00_axis_tready),
        .s_dat (s_dat),
        .m_vld (m00_axis_tvalid),
        .m_rdy (m00_axis_tready),
        .m_dat (m_dat)
    );

    assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tuser} = m_dat;

    geom_state_e         state_q, state_nxt;
    logic [DIM_BITS-1:0] x_q, x_nxt, y_q, y_nxt, w_q, w_nxt, h_q, h_nxt;
    logic [DIM_BITS-1:0] pos_x, pos_y, lim_w, lim_h;
    logic                ferr_q, ferr_nxt;
    logic                beat_acc, start, do_geom, last_col, eol;
    logic                ev_no_sof, ev_sof_mid, ev_early, ev_late, ev_cfg;
    logic                frame_end, frame_ok;

    assign beat_acc = s00_axis_tvalid & s00_axis_tready;

    always_comb begin
        state_nxt  = state_q;
        x_nxt      = x_q;
        y_nxt      = y_q;
        w_nxt      = w_q;
        h_nxt      = h_q;
        ferr_nxt   = ferr_q;
        pos_x      = x_q;
        pos_y      = y_q;
        lim_w      = w_q;
        lim_h      = h_q;
        start      = 1'b0;
        do_geom    = 1'b0;
        last_col   = 1'b0;
        eol        = 1'b0;
        ev_no_sof  = 1'b0;
        ev_sof_mid = 1'b0;
        ev_early   = 1'b0;
        ev_late    = 1'b0;
        ev_cfg     = 1'b0;
        frame_end  = 1'b0;
        frame_ok   = 1'b0;
        if (beat_acc) begin
            case (state_q)
                ST_IDLE, ST_BYPASS: begin
                    if (s00_axis_tuser) begin
                        start = 1'b1;
                    end else if (state_q == ST_IDLE) begin
                        ev_no_sof = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (s00_axis_tuser && (x_q != '0 || y_q != '0)) begin
                        ev_sof_mid = 1'b1;
                        start      = 1'b1;
                    end else begin
                        do_geom = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            // The SOF beat itself is pixel (0,0) of the new frame, checked
            // against the freshly latched geometry.
            if (start) begin
                w_nxt    = cfg_width;
                h_nxt    = cfg_height;
                ferr_nxt = 1'b0;
                pos_x    = '0;
                pos_y    = '0;
                lim_w    = cfg_width;
                lim_h    = cfg_height;
                x_nxt    = '0;
                y_nxt    = '0;
                if (cfg_width == '0 || cfg_height == '0) begin
                    ev_cfg    = 1'b1;
                    state_nxt = ST_BYPASS;
                end else begin
                    do_geom   = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            if (do_geom) begin
                last_col = (pos_x == lim_w - DIM_ONE);
                eol      = s00_axis_tlast | last_col;
                ev_early = s00_axis_tlast & ~last_col;
                ev_late  = ~s00_axis_tlast & last_col;
                if (eol) begin
                    // A mismatched tlast still closes the line so the
                    // checker resynchronises on the next one.
                    x_nxt = '0;
                    y_nxt = pos_y + DIM_ONE;
                    if (pos_y == lim_h - DIM_ONE) begin
                        frame_end = 1'b1;
                        frame_ok  = ~(ferr_nxt | ev_early | ev_late);
                        y_nxt     = '0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    x_nxt = pos_x + DIM_ONE;
                end
                if (ev_early | ev_late) begin
                    ferr_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            h_q           <= '0;
            ferr_q        <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            err_no_sof    <= 1'b0;
            err_sof_mid   <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
            err_cfg       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            w_q        <= w_nxt;
            h_q        <= h_nxt;
            ferr_q     <= ferr_nxt;
            frame_done <= frame_end & frame_ok;
            if (frame_end) begin
                frame_count <= frame_count + FC_ONE;
            end
            // Set events take priority over a simultaneous clear.
            err_no_sof    <= ev_no_sof  | (err_no_sof    & ~clr_err);
            err_sof_mid   <= ev_sof_mid | (err_sof_mid   & ~clr_err);
            err_eol_early <= ev_early   | (err_eol_early & ~clr_err);
            err_eol_late  <= ev_late    | (err_eol_late  & ~clr_err);
            err_cfg       <= ev_cfg     | (err_cfg       & ~clr_err);
        end
    end

endmodule

// File: tb/tb_crop_video_axis_geom_chk.sv
// Purpose: scoreboard bench for the geometry checker and its forwarding path.
// Latency: expects beats one cycle after acceptance, frame_done one cycle after the last beat.
// Backpressure: drives fixed and random m00 tready and honours s00 tready.
module tb_crop_video_axis_geom_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s00_axis_tvalid = 1'b0;
    logic        s00_axis_tready;
    logic [31:0] s00_axis_tdata = '0;
    logic [3:0]  s00_axis_tstrb = '0;
    logic        s00_axis_tlast = 1'b0;
    logic        s00_axis_tuser = 1'b0;
    logic        m00_axis_tvalid;
    logic        m00_axis_tready = 1'b1;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;
    logic        m00_axis_tlast;
    logic        m00_axis_tuser;
    logic [11:0] cfg_width = 12'd4;
    logic [11:0] cfg_height = 12'd3;
    logic        clr_err = 1'b0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_no_sof, err_sof_mid, err_eol_early, err_eol_late, err_cfg;

    crop_video_axis_geom_chk dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tstrb  (s00_axis_tstrb),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tuser  (s00_axis_tuser),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tuser  (m00_axis_tuser),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .clr_err         (clr_err),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .err_no_sof      (err_no_sof),
        .err_sof_mid     (err_sof_mid),
        .err_eol_early   (err_eol_early),
        .err_eol_late    (err_eol_late),
        .err_cfg         (err_cfg)
    );

    initial forever #5 clk = ~clk;

    logic [37:0] exp_q[$];
    logic [37:0] mon_got, mon_exp;
    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    int          done_cnt = 0;
    logic        rand_en = 1'b0;
    logic [4:0]  errs;

    assign errs = {err_no_sof, err_sof_mid, err_eol_early, err_eol_late, err_cfg};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
        int t;
        t = 0;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = d;
        s00_axis_tstrb  = s;
        s00_axis_tlast  = l;
        s00_axis_tuser  = u;
        while (!s00_axis_tready) begin
            stalls++;
            @(negedge clk);
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got tready 0 for %0d cycles expected accept", t);
                s00_axis_tvalid = 1'b0;
                return;
            end
        end
        exp_q.push_back({d, s, l, u});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s00_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rand_en = 1'b0;
        m00_axis_tready = 1'b1;
        s00_axis_tvalid = 1'b0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s00_axis_tvalid = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        done_cnt = 0;
        stalls = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && m00_axis_tvalid && m00_axis_tready) begin
                    mon_got = {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, m00_axis_tuser};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected got %h expected no beat", mon_got);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_got !== mon_exp) begin
                            errors++;
                            $display("FAIL out_beat got %h expected %h", mon_got, mon_exp);
                        end
                    end
                end
                if (!rst && frame_done) done_cnt++;
            end
            forever begin
                @(posedge clk);
                #1;
                if (rand_en) m00_axis_tready = 1'($urandom_range(0, 1));
            end
            begin
                #400000;
                $display("FAIL watchdog got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chk("rst_tready", s00_axis_tready, 0);
        chk("rst_m_tvalid", m00_axis_tvalid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_errs", errs, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_tready", s00_axis_tready, 1);

        // Three clean 4x3 frames; cfg wiggles mid-frame must be ignored.
        cfg_width = 12'd4; cfg_height = 12'd3;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 12; b++) begin
                if (b == 1) cfg_width = 12'd9;
                if (b == 11) cfg_width = 12'd4;
                send({8'hA0, 8'(f), 16'(b)}, 4'(b), (b % 4) == 3, b == 0);
            end
        end
        chk("a_stalls", stalls, 0);
        drain();
        chk("a_done", done_cnt, 3);
        chk("a_frame_count", frame_count, 3);
        chk("a_errs", errs, 0);

        // Early tlast on the third beat of the first line.
        do_reset();
        for (int b = 0; b < 11; b++) begin
            send({8'hB0, 8'h00, 16'(b)}, 4'hF, (b == 2) || (b == 6) || (b == 10), b == 0);
        end
        drain();
        chk("b_eol_early", err_eol_early, 1);
        chk("b_eol_late", err_eol_late, 0);
        chk("b_done", done_cnt, 0);
        chk("b_frame_count", frame_count, 1);

        // Missing tlast at end of first line (late), then 4 + 4 beats.
        do_reset();
        for (int b = 0; b < 12; b++) begin
            send({8'hB8, 8'h00, 16'(b)}, 4'h3, (b == 7) || (b == 11), b == 0);
        end
        drain();
        chk("b2_eol_late", err_eol_late, 1);
        chk("b2_eol_early", err_eol_early, 0);
        chk("b2_done", done_cnt, 0);
        chk("b2_frame_count", frame_count, 1);

        // 4x2 with a second SOF on beat 5; the restarted frame is clean.
        do_reset();
        cfg_width = 12'd4; cfg_height = 12'd2;
        for (int b = 0; b < 12; b++) begin
            send({8'hC0, 8'h00, 16'(b)}, 4'h5, (b % 4) == 3, (b == 0) || (b == 4));
        end
        drain();
        chk("c_sof_mid", err_sof_mid, 1);
        chk("c_done", done_cnt, 1);
        chk("c_frame_count", frame_count, 1);
        chk("c_eol_errs", {err_eol_early, err_eol_late}, 0);

        // Random downstream backpressure over two 4x3 frames.
        do_reset();
        cfg_width = 12'd4; cfg_height = 12'd3;
        rand_en = 1'b1;
        for (int b = 0; b < 24; b++) begin
            send({8'hD0, 8'h00, 16'(b)}, 4'(b + 3), (b % 4) == 3, (b % 12) == 0);
        end
        drain();
        chk("d_done", done_cnt, 2);
        chk("d_frame_count", frame_count, 2);
        chk("d_errs", errs, 0);

        // Zero width at SOF: bypass, stream still forwarded, then clear.
        do_reset();
        cfg_width = 12'd0; cfg_height = 12'd3;
        for (int b = 0; b < 6; b++) begin
            send({8'hE0, 8'h00, 16'(b)}, 4'h9, b == 2, b == 0);
        end
        drain();
        chk("e_err_cfg", err_cfg, 1);
        chk("e_no_sof", err_no_sof, 0);
        chk("e_frame_count", frame_count, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("e_cleared", errs, 0);

        // Reset in the middle of line 1 with both skid entries full.
        do_reset();
        cfg_width = 12'd4; cfg_height = 12'd3;
        m00_axis_tready = 1'b0;
        send(32'hF000_0000, 4'hF, 1'b0, 1'b1);
        send(32'hF000_0001, 4'hF, 1'b0, 1'b0);
        idle(0);
        chk("f_full_tready", s00_axis_tready, 0);
        chk("f_full_m_tvalid", m00_axis_tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("f_rst_m_tvalid", m00_axis_tvalid, 0);
        chk("f_rst_tready", s00_axis_tready, 0);
        chk("f_rst_errs", errs, 0);
        exp_q.delete();
        rst = 1'b0;
        m00_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        send(32'hF000_0002, 4'hF, 1'b0, 1'b0);
        drain();
        chk("f_no_sof", err_no_sof, 1);
        chk("f_frame_count", frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
